// File: rtl/signal_cfg_loader.sv
// Channel configuration loader: a register-bus port fills a shadow copy of the
// channel configuration word, which is committed atomically to cfg_data either
// immediately or at the next ramp-period sync pulse.
module signal_cfg_loader #(
    parameter int NUM_WORDS = 26,
    parameter int CNT_W     = 16
) (
    input  logic                    aclk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [4:0]              wr_addr,
    input  logic [31:0]             wr_data,
    output logic                    wr_err,
    input  logic [4:0]              rd_addr,
    output logic [31:0]             rd_data,
    input  logic                    commit_req,
    input  logic                    commit_mode,
    input  logic                    abort,
    input  logic                    sync_pulse,
    output logic [NUM_WORDS*32-1:0] cfg_data,
    output logic                    armed,
    output logic                    dirty,
    output logic                    commit_done,
    output logic [CNT_W-1:0]        commit_cnt
);

    localparam int unsigned NW        = NUM_WORDS;
    localparam logic [4:0]  LAST_ADDR = 5'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COMMIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] shadow [NUM_WORDS];
    logic        wr_accept;
    logic        wr_in_range;
    logic        rd_in_range;

    assign wr_in_range = (wr_addr <= LAST_ADDR);
    assign rd_in_range = (rd_addr <= LAST_ADDR);

    // Upper halfwords of the reserved words never reach the channel.
    function automatic logic [31:0] visible_word(input int unsigned k, input logic [31:0] w);
        if (k == 5 || k == 7 || k == 13 || k == 19 || k == 25)
            return {16'h0000, w[15:0]};
        return w;
    endfunction

    // Next-state and write-acceptance decode.
    always_comb begin
        state_next = state;
        wr_accept  = 1'b0;
        case (state)
            S_IDLE: begin
                wr_accept = wr_en && wr_in_range;
                if (commit_req)
                    state_next = commit_mode ? S_ARMED : S_COMMIT;
            end
            S_ARMED: begin
                // abort takes priority over a coincident sync_pulse
                if (abort)
                    state_next = S_IDLE;
                else if (sync_pulse)
                    state_next = S_COMMIT;
            end
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Shadow storage, write error pulse and dirty flag.
    always_ff @(posedge aclk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NW; k++)
                shadow[k] <= '0;
            wr_err <= 1'b0;
            dirty  <= 1'b0;
        end else begin
            if (wr_accept)
                shadow[wr_addr] <= wr_data;
            wr_err <= wr_en && !wr_accept;
            if (wr_accept)
                dirty <= 1'b1;
            else if (state == S_COMMIT)
                dirty <= 1'b0;
        end
    end

    // Registered shadow readback; out-of-range addresses read as zero.
    always_ff @(posedge aclk) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= rd_in_range ? shadow[rd_addr] : '0;
    end

    // Armed flag: held through the commit cycle, dropped on abort.
    always_ff @(posedge aclk) begin
        if (reset)
            armed <= 1'b0;
        else if (state == S_IDLE && commit_req && commit_mode)
            armed <= 1'b1;
        else if ((state == S_ARMED && abort) || state == S_COMMIT)
            armed <= 1'b0;
    end

    // Atomic commit of the masked shadow into the active configuration.
    always_ff @(posedge aclk) begin
        if (reset) begin
            cfg_data    <= '0;
            commit_done <= 1'b0;
            commit_cnt  <= '0;
        end else begin
            commit_done <= (state == S_COMMIT);
            if (state == S_COMMIT) begin
                for (int unsigned k = 0; k < NW; k++)
                    cfg_data[32*k +: 32] <= visible_word(k, shadow[k]);
                commit_cnt <= commit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_signal_cfg_loader.sv
// Scoreboard bench for signal_cfg_loader: commits push expected cfg/count/cycle
// into a queue; a monitor pops on every commit_done and compares.
module tb_signal_cfg_loader;

    logic         aclk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         wr_err;
    logic [4:0]   rd_addr;
    logic [31:0]  rd_data;
    logic         commit_req;
    logic         commit_mode;
    logic         abort;
    logic         sync_pulse;
    logic [831:0] cfg_data;
    logic         armed;
    logic         dirty;
    logic         commit_done;
    logic [15:0]  commit_cnt;

    // narrow-counter instance, same stimulus, to exercise the wrap cheaply
    logic         s_wr_err;
    logic [31:0]  s_rd_data;
    logic [831:0] s_cfg_data;
    logic         s_armed;
    logic         s_dirty;
    logic         s_commit_done;
    logic [3:0]   s_commit_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [831:0] cfg;
        logic [15:0]  cnt;
        int           at;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_shadow [26];
    logic [15:0] exp_cnt;

    signal_cfg_loader #(.NUM_WORDS(26), .CNT_W(16)) dut (
        .aclk(aclk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .rd_addr(rd_addr), .rd_data(rd_data), .commit_req(commit_req),
        .commit_mode(commit_mode), .abort(abort), .sync_pulse(sync_pulse), .cfg_data(cfg_data),
        .armed(armed), .dirty(dirty), .commit_done(commit_done), .commit_cnt(commit_cnt)
    );

    signal_cfg_loader #(.NUM_WORDS(26), .CNT_W(4)) dut_small (
        .aclk(aclk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(s_wr_err), .rd_addr(rd_addr), .rd_data(s_rd_data), .commit_req(commit_req),
        .commit_mode(commit_mode), .abort(abort), .sync_pulse(sync_pulse), .cfg_data(s_cfg_data),
        .armed(s_armed), .dirty(s_dirty), .commit_done(s_commit_done), .commit_cnt(s_commit_cnt)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [831:0] model_cfg();
        logic [831:0] c;
        for (int k = 0; k < 26; k++) begin
            if (k == 5 || k == 7 || k == 13 || k == 19 || k == 25)
                c[32*k +: 32] = {16'h0000, m_shadow[k][15:0]};
            else
                c[32*k +: 32] = m_shadow[k];
        end
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 26; k++) m_shadow[k] = '0;
        exp_cnt = '0;
    endtask

    task automatic push_commit(input int at);
        exp_t e;
        exp_cnt = exp_cnt + 16'd1;
        e.cfg = model_cfg();
        e.cnt = exp_cnt;
        e.at  = at;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // one-cycle write; returns in the cycle where wr_err for it is visible
    task automatic write_word(input logic [4:0] a, input logic [31:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (accept) m_shadow[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    // immediate commit; returns in cycle N+2 when the new cfg is visible
    task automatic commit_imm();
        commit_req  = 1'b1;
        commit_mode = 1'b0;
        push_commit(cyc + 2);
        tick();
        commit_req = 1'b0;
        tick();
    endtask

    task automatic arm();
        commit_req  = 1'b1;
        commit_mode = 1'b1;
        tick();
        commit_req  = 1'b0;
        commit_mode = 1'b0;
    endtask

    // Monitor: every commit_done must match the oldest pending expectation.
    always @(negedge aclk) begin
        if (!reset) begin
            if (q.size() > 0 && q[0].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL commit_missing: got none expected commit_done at cycle %0d", q[0].at);
                void'(q.pop_front());
            end
            if (commit_done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL commit_spurious: got commit_done at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checks++;
                    if (e.at != cyc) begin
                        errors++;
                        $display("FAIL commit_cycle: got %0d expected %0d", cyc, e.at);
                    end
                    checks++;
                    if (cfg_data !== e.cfg) begin
                        errors++;
                        $display("FAIL commit_cfg: got %0h expected %0h", cfg_data, e.cfg);
                    end
                    checks++;
                    if (commit_cnt !== e.cnt) begin
                        errors++;
                        $display("FAIL commit_cnt: got %0d expected %0d", commit_cnt, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        commit_req = 1'b0; commit_mode = 1'b0; abort = 1'b0; sync_pulse = 1'b0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        reset = 1'b0;

        // reset state
        check("rst_cfg_any", {63'b0, |cfg_data}, 64'd0);
        check("rst_cnt", commit_cnt, 0);
        check("rst_armed", armed, 0);
        check("rst_dirty", dirty, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_done", commit_done, 0);
        check("rst_rd_data", rd_data, 0);

        // 1: two words, immediate commit
        write_word(5'd0, 32'h89ABCDEF, 1);
        write_word(5'd1, 32'h00011234, 1);
        check("t1_dirty", dirty, 1);
        commit_imm();
        check("t1_cfg_lo", cfg_data[63:0], 64'h0001123489ABCDEF);
        check("t1_cnt", commit_cnt, 1);
        check("t1_dirty_clr", dirty, 0);

        // 2: reserved halfword masked in cfg, kept in shadow
        write_word(5'd5, 32'hFFFFFFFF, 1);
        commit_imm();
        check("t2_cfg_w5", cfg_data[191:160], 64'h0000FFFF);
        rd_addr = 5'd5;
        tick();
        check("t2_rd_w5", rd_data, 64'hFFFFFFFF);
        rd_addr = 5'd26;
        tick();
        check("t2_rd_oor", rd_data, 0);

        // 3: synced commit, coincident sync ignored, write while armed rejected
        write_word(5'd2, 32'h12345678, 1);
        sync_pulse = 1'b1;
        arm();
        sync_pulse = 1'b0;
        wr_addr = 5'd3;
        wr_data = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            check("t3_armed", armed, 1);
            check("t3_cfg_hold", cfg_data[95:64], 0);
            if (i == 4) check("t3_wr_err", wr_err, 1);
            wr_en = (i == 3);
            tick();
        end
        wr_en = 1'b0;
        sync_pulse = 1'b1;
        push_commit(cyc + 2);
        tick();
        sync_pulse = 1'b0;
        check("t3_cfg_m1", cfg_data[95:64], 0);
        tick();
        check("t3_cfg_m2", cfg_data[95:64], 64'h12345678);
        check("t3_armed_clr", armed, 0);
        rd_addr = 5'd3;
        tick();
        check("t3_rd_w3", rd_data, 0);

        // 4: abort beats coincident sync
        write_word(5'd4, 32'hAAAA5555, 1);
        arm();
        tick();
        tick();
        check("t4_armed", armed, 1);
        abort = 1'b1;
        sync_pulse = 1'b1;
        tick();
        abort = 1'b0;
        sync_pulse = 1'b0;
        check("t4_armed_clr", armed, 0);
        check("t4_dirty", dirty, 1);
        check("t4_cnt", commit_cnt, 3);
        repeat (3) tick();
        check("t4_cfg_w4", cfg_data[159:128], 0);

        // 5: out-of-range write, then write + commit in the same cycle
        write_word(5'd26, 32'h55555555, 0);
        check("t5_wr_err", wr_err, 1);
        tick();
        check("t5_wr_err_pulse", wr_err, 0);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFEF00D;
        m_shadow[6] = 32'hCAFEF00D;
        commit_req = 1'b1; commit_mode = 1'b0;
        push_commit(cyc + 2);
        tick();
        wr_en = 1'b0;
        commit_req = 1'b0;
        tick();
        check("t5_cfg_w6", cfg_data[223:192], 64'hCAFEF00D);
        check("t5_cfg_w4", cfg_data[159:128], 64'hAAAA5555);

        // 6: reset while armed, then counter wrap
        write_word(5'd7, 32'h11112222, 1);
        arm();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("t6_cfg_any", {63'b0, |cfg_data}, 64'd0);
        check("t6_armed", armed, 0);
        check("t6_cnt", commit_cnt, 0);
        check("t6_small_cnt", s_commit_cnt, 0);
        write_word(5'd7, 32'h99998888, 1);
        for (int i = 0; i < 17; i++) commit_imm();
        check("t6_cfg_w7", cfg_data[255:224], 64'h00008888);
        check("t6_cnt17", commit_cnt, 17);
        check("t6_small_wrap", s_commit_cnt, 1);

        repeat (4) tick();
        check("pending_commits", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
